// File: rtl/sum_loop_controller.sv
// sum_loop_controller: sequences the summation datapath (init, accumulate while i<e, output)
// behind a start/done handshake, with an iteration watchdog that parks the FSM in ERR.
module sum_loop_controller #(
  parameter int DATA_W   = 32,
  parameter int MAX_ITER = 1024,
  parameter int ITER_W   = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] i_val,
  input  logic [DATA_W-1:0] e_val,
  output logic              Enable3,
  output logic              Enable6,
  output logic              Enable7,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter_count
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] INIT  = 3'd1;
  localparam logic [2:0] CHECK = 3'd2;
  localparam logic [2:0] ACC   = 3'd3;
  localparam logic [2:0] OUT   = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] ERR   = 3'd6;

  logic [2:0] state, state_nx;
  logic       more;

  assign more = i_val < e_val;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? INIT : IDLE;
      INIT:    state_nx = CHECK;
      CHECK:   state_nx = !more ? OUT : (iter_count == ITER_W'(MAX_ITER)) ? ERR : ACC;
      ACC:     state_nx = CHECK;
      OUT:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      ERR:     state_nx = start ? ERR : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are flopped from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      iter_count <= '0;
      Enable3    <= 1'b0;
      Enable6    <= 1'b0;
      Enable7    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state   <= state_nx;
      Enable3 <= state_nx == INIT;
      Enable6 <= state_nx == ACC;
      Enable7 <= state_nx == OUT;
      done    <= state_nx == DONE;
      err     <= state_nx == ERR;
      busy    <= state_nx != IDLE && state_nx != ERR;
      if (state == IDLE && start)
        iter_count <= '0;
      else if (state_nx == ACC)
        iter_count <= iter_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_sum_loop_controller.sv
// tb_sum_loop_controller: random runs against a closed-form model of the summation loop,
// with a scoreboard queue checked by a monitor on every done/err event.
module tb_sum_loop_controller;
  localparam int M = 24;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] i_val, e_val;
  logic        Enable3, Enable6, Enable7, busy, done, err;
  logic [4:0]  iter_count;

  sum_loop_controller #(.DATA_W(32), .MAX_ITER(M), .ITER_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .i_val(i_val), .e_val(e_val),
    .Enable3(Enable3), .Enable6(Enable6), .Enable7(Enable7),
    .busy(busy), .done(done), .err(err), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: e is loaded from e_init so each run picks its own bound.
  logic [31:0] sum = 0, i_r = 0, e_r = 0, result = 0, e_init = 20;
  assign i_val = i_r;
  assign e_val = e_r;
  always @(posedge clk) begin
    if (Enable3) begin sum <= 0; i_r <= 0; e_r <= e_init; end
    if (Enable6) begin sum <= sum + i_r; i_r <= i_r + 1; end
    if (Enable7) result <= sum;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    int          e3_cyc;
    int          end_cyc;
    int          iters;
    logic [31:0] res;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  int   e3_seen = -1, e6_cnt = 0;
  logic err_q = 1'b0;
  exp_t ex;
  always @(negedge clk) begin
    if (!rst_n) begin
      e6_cnt = 0;
      err_q  = 1'b0;
    end else begin
      chk("onehot_enables", $onehot0({Enable3, Enable6, Enable7}), 1);
      chk("done_with_enable", done && (Enable3 || Enable6 || Enable7), 0);
      if (Enable3) begin e3_seen = cyc; e6_cnt = 0; end
      if (Enable6) e6_cnt++;
      if (done || (err && !err_q)) begin
        chk("pending_expectation", q.size() != 0, 1);
        if (q.size() != 0) begin
          ex = q.pop_front();
          chk("end_kind_err", err, ex.is_err);
          chk("enable3_cycle", e3_seen, ex.e3_cyc);
          chk("end_cycle", cyc, ex.end_cyc);
          chk("iter_count", iter_count, ex.iters);
          chk("enable6_pulses", e6_cnt, ex.iters);
          if (ex.is_err) chk("busy_in_err", busy, 0);
          else chk("result", result, ex.res);
        end
      end
      err_q = err;
    end
  end

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic launch(input int unsigned n, input bit toggle, input bit chain);
    exp_t e;
    int   c;
    e_init = n;
    start  = 1'b1;
    c      = cyc;
    e.e3_cyc = c + 1;
    if (n > M) begin
      e.is_err = 1; e.iters = M; e.end_cyc = c + 2 * M + 3; e.res = 0;
    end else begin
      e.is_err = 0; e.iters = int'(n); e.end_cyc = c + 2 * int'(n) + 4;
      e.res = n * (n - 1) / 2;
    end
    q.push_back(e);
    if (e.is_err) begin
      repeat (2 * M + 7) @(negedge clk);
      chk("err_held", err, 1);
      chk("busy_low_in_err", busy, 0);
      start = 1'b0;
      @(negedge clk);
      chk("err_cleared", err, 0);
      chk("busy_after_err", busy, 0);
    end else begin
      while (cyc < e.end_cyc) begin
        @(negedge clk);
        start = (cyc == e.end_cyc) ? chain : (toggle ? 1'($urandom_range(0, 1)) : 1'b0);
      end
      @(negedge clk);
    end
  endtask

  task automatic reset_mid_acc();
    e_init = 20;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_reset_in_acc", Enable6, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_strobes", {Enable3, Enable6, Enable7}, 0);
    chk("async_reset_flags", {busy, done, err}, 0);
    chk("async_reset_iter", iter_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_after_reset", {Enable3, Enable6, Enable7, busy, done, err}, 0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs", {Enable3, Enable6, Enable7, busy, done, err}, 0);
    chk("reset_iter", iter_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    launch(20, 0, 0);
    launch(0, 0, 0);
    launch(M, 0, 0);
    launch(32'hFFFF_FFFF, 0, 0);
    launch(M + 1, 0, 0);
    launch(3, 0, 1);
    launch(5, 1, 1);
    launch(1, 1, 0);
    for (int k = 0; k < 12; k++)
      launch($urandom_range(0, M + 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    reset_mid_acc();
    launch(7, 0, 0);
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end
endmodule
